// File: rtl/input_sample_fifo.sv
// Sample FIFO feeding the jimmy CPU in_port_0; each falling edge of in_strobe advances to the next sample.
// Latency: a push shows on in_port 1 cycle after it is accepted; a pop moves the head 1 cycle after the strobe falls.
// Backpressure: wr_ready = !full. A pop never frees space for a push in the same cycle.
module input_sample_fifo #(
    parameter int              WIDTH       = 8,
    parameter int              DEPTH       = 16,
    parameter logic [WIDTH-1:0] EMPTY_VALUE = 8'h00
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [WIDTH-1:0]         in_port,
    input  logic                     in_strobe,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     underflow,
    output logic [7:0]               pop_total
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             strobe_d;
    logic             pop_req;
    logic             push_en;
    logic             pop_en;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign wr_ready = !full;

    // Pop request is the strobe's falling edge, seen one cycle late.
    assign pop_req  = strobe_d && !in_strobe;
    assign push_en  = wr_valid && wr_ready;
    assign pop_en   = pop_req && !empty;

    assign in_port  = empty ? EMPTY_VALUE : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            strobe_d  <= 1'b0;
            underflow <= 1'b0;
            pop_total <= 8'd0;
        end else begin
            strobe_d <= in_strobe;
            if (push_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_en) begin
                rd_ptr    <= rd_ptr + AW'(1);
                pop_total <= pop_total + 8'd1;
            end
            if (pop_req && empty) begin
                underflow <= 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; empty masks stale entries.
    always_ff @(posedge clk) begin
        if (push_en && !reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_input_sample_fifo.sv
// Bench for input_sample_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_input_sample_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] in_port;
    logic       in_strobe;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       underflow;
    logic [7:0] pop_total;

    int checks = 0;
    int errors = 0;

    byte unsigned q[$];
    bit           m_uf;
    int           m_pop;
    bit           m_prev;

    always #5 clk = ~clk;

    input_sample_fifo #(.WIDTH(8), .DEPTH(DEPTH), .EMPTY_VALUE(8'h00)) dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .in_port(in_port), .in_strobe(in_strobe),
        .count(count), .empty(empty), .full(full), .underflow(underflow),
        .pop_total(pop_total)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        logic [7:0] head;
        head = (q.size() > 0) ? q[0] : 8'h00;
        check_val("count", 32'(count), 32'(q.size()));
        check_val("empty", 32'(empty), 32'(q.size() == 0));
        check_val("full", 32'(full), 32'(q.size() == DEPTH));
        check_val("wr_ready", 32'(wr_ready), 32'(q.size() != DEPTH));
        check_val("in_port", 32'(in_port), 32'(head));
        check_val("underflow", 32'(underflow), 32'(m_uf));
        check_val("pop_total", 32'(pop_total), 32'(m_pop));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input bit rst, input bit v, input logic [7:0] d, input bit s);
        bit pr;
        bit acc;
        reset = rst; wr_valid = v; wr_data = d; in_strobe = s;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_uf = 0; m_pop = 0; m_prev = 0;
        end else begin
            pr  = m_prev && !s;
            acc = v && (q.size() < DEPTH);
            if (pr) begin
                if (q.size() > 0) begin
                    void'(q.pop_front());
                    m_pop = (m_pop + 1) % 256;
                end else begin
                    m_uf = 1;
                end
            end
            if (acc) q.push_back(d);
            m_prev = s;
        end
        #1;
        compare_all();
    endtask

    initial begin
        logic [7:0] avg [10];
        bit s;
        avg = '{8'd5, 8'd3, 8'd4, 8'd5, 8'd7, 8'd2, 8'd9, 8'd6, 8'd7, 8'd4};
        reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; in_strobe = 1'b0;

        // Reset held 2 cycles with wr_valid high
        step(1, 1, 8'h55, 0);
        step(1, 1, 8'h66, 0);
        check_val("rst_count", 32'(count), 0);
        check_val("rst_in_port", 32'(in_port), 0);

        // Averaging feed
        for (int i = 0; i < 10; i++) step(0, 1, avg[i], 0);
        step(0, 0, 8'h00, 0);
        for (int i = 0; i < 10; i++) begin
            check_val("avg_head", 32'(in_port), 32'(avg[i]));
            step(0, 0, 8'h00, 1);
            step(0, 0, 8'h00, 1);
            for (int k = 0; k < 4; k++) step(0, 0, 8'h00, 0);
        end
        check_val("avg_pop_total", 32'(pop_total), 10);
        check_val("avg_empty", 32'(empty), 1);

        // Full boundary
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'(100 + i), 0);
        check_val("full_count", 32'(count), 16);
        check_val("full_flag", 32'(full), 1);
        check_val("full_ready", 32'(wr_ready), 0);
        step(0, 1, 8'd116, 0);
        check_val("full_17th_refused", 32'(count), 16);
        step(0, 1, 8'd116, 1);
        step(0, 1, 8'd116, 0);
        check_val("full_pop_count", 32'(count), 15);
        check_val("full_pop_ready", 32'(wr_ready), 1);
        step(0, 1, 8'd116, 0);
        check_val("full_17th_taken", 32'(count), 16);
        step(0, 0, 8'h00, 0);

        // Underflow
        step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        check_val("uf_flag", 32'(underflow), 1);
        check_val("uf_pop_total", 32'(pop_total), 0);
        check_val("uf_in_port", 32'(in_port), 0);
        step(0, 1, 8'h2A, 0);
        step(0, 0, 8'h00, 0);
        check_val("uf_push_head", 32'(in_port), 32'h2A);
        check_val("uf_sticky", 32'(underflow), 1);

        // Wrap with simultaneous push and pop at count 1
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'd0, 0);
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 8'h00, 1);
            step(0, 1, 8'(i), 0);
            check_val("wrap_count", 32'(count), 1);
            check_val("wrap_head", 32'(in_port), 32'(i));
            step(0, 0, 8'h00, 0);
        end

        // Reset while strobe is high, then strobe drops
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 8'(200 + i), 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 8'h00, 1);
            step(0, 0, 8'h00, 0);
            step(0, 0, 8'h00, 0);
        end
        check_val("mid_count_before", 32'(count), 4);
        step(0, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        check_val("mid_count", 32'(count), 0);
        check_val("mid_pop_total", 32'(pop_total), 0);
        check_val("mid_underflow", 32'(underflow), 0);

        // Random traffic
        s = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) s = ~s;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
                 8'($urandom_range(0, 255)), s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
